cv_bus_master: RTL and testbench

Z80-style bus-cycle initiator that issues Colecovision/Adam memory and I/O read/write cycles.
- Generates the address, data and strobes (mreq_n, iorq_n, rd_n, wr_n, rfsh_n) that the system address decoder consumes.
- Used by the host loader/debug path to poke RAM, set the memory map (port 0x7F) and access VDP/PSG/AY ports without the CPU.
- Accepts one command at a time over a valid/ready interface and returns read data or an error on a one-cycle response strobe.

---
 rtl/cv_bus_master.sv | 151 +++++++++++++++
 tb/tb_cv_bus_master.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cv_bus_master.sv
// Z80-style bus-cycle initiator for Colecovision/Adam memory and I/O cycles.
// Lets the host loader/debug path drive the system bus one command at a time.
module cv_bus_master #(
  parameter int IO_WAIT    = 1,
  parameter int WAIT_MAX   = 16,
  parameter bit REFRESH_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        clk_en_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_io_i,
  input  logic        cmd_wr_i,
  input  logic [15:0] cmd_addr_i,
  input  logic [7:0]  cmd_wdata_i,
  output logic        rsp_valid_o,
  output logic [7:0]  rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [15:0] a_o,
  output logic [7:0]  d_o,
  output logic        d_oe_o,
  input  logic [7:0]  d_i,
  output logic        mreq_n_o,
  output logic        iorq_n_o,
  output logic        rd_n_o,
  output logic        wr_n_o,
  output logic        rfsh_n_o,
  input  logic        wait_n_i
);

  typedef enum logic [2:0] {IDLE, T1, T2, TW, T3, RF1, RF2} state_t;

  state_t      state;
  logic        io_q;
  logic        wr_q;
  logic [1:0]  io_cnt;
  logic [7:0]  wait_cnt;
  logic [6:0]  r_cnt;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state       <= IDLE;
      io_q        <= 1'b0;
      wr_q        <= 1'b0;
      io_cnt      <= 2'd0;
      wait_cnt    <= 8'd0;
      r_cnt       <= 7'd0;
      a_o         <= 16'h0000;
      d_o         <= 8'h00;
      d_oe_o      <= 1'b0;
      mreq_n_o    <= 1'b1;
      iorq_n_o    <= 1'b1;
      rd_n_o      <= 1'b1;
      wr_n_o      <= 1'b1;
      rfsh_n_o    <= 1'b1;
      cmd_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= 8'h00;
      rsp_err_o   <= 1'b0;
    end else begin
      rsp_valid_o <= 1'b0;
      unique case (state)
        // Ready comes back one cycle after re-entering IDLE, so it never overlaps rsp_valid.
        IDLE: begin
          if (!cmd_ready_o) begin
            cmd_ready_o <= 1'b1;
          end else if (cmd_valid_i) begin
            io_q        <= cmd_io_i;
            wr_q        <= cmd_wr_i;
            a_o         <= cmd_addr_i;
            if (cmd_wr_i) d_o <= cmd_wdata_i;
            d_oe_o      <= cmd_wr_i;
            cmd_ready_o <= 1'b0;
            state       <= T1;
          end
        end
        T1: if (clk_en_i) begin
          mreq_n_o <= io_q;
          iorq_n_o <= !io_q;
          rd_n_o   <= wr_q;
          wr_n_o   <= !wr_q;
          wait_cnt <= 8'd0;
          io_cnt   <= io_q ? 2'(IO_WAIT) : 2'd0;
          state    <= T2;
        end
        T2: if (clk_en_i) begin
          if (io_cnt != 2'd0) begin
            state <= TW;
          end else if (!wait_n_i) begin
            wait_cnt <= 8'd1;
            state    <= TW;
          end else begin
            state <= T3;
          end
        end
        // Mandatory I/O waits run out first; wait_n is sampled on the last one and after.
        TW: if (clk_en_i) begin
          if (io_cnt > 2'd1) begin
            io_cnt <= io_cnt - 2'd1;
          end else begin
            io_cnt <= 2'd0;
            if (wait_n_i) begin
              state <= T3;
            end else if (wait_cnt == 8'(WAIT_MAX)) begin
              mreq_n_o    <= 1'b1;
              iorq_n_o    <= 1'b1;
              rd_n_o      <= 1'b1;
              wr_n_o      <= 1'b1;
              d_oe_o      <= 1'b0;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
              rsp_rdata_o <= 8'hFF;
              state       <= IDLE;
            end else begin
              wait_cnt <= wait_cnt + 8'd1;
            end
          end
        end
        T3: if (clk_en_i) begin
          mreq_n_o    <= 1'b1;
          iorq_n_o    <= 1'b1;
          rd_n_o      <= 1'b1;
          wr_n_o      <= 1'b1;
          d_oe_o      <= 1'b0;
          rsp_valid_o <= 1'b1;
          rsp_err_o   <= 1'b0;
          rsp_rdata_o <= wr_q ? 8'h00 : d_i;
          // Refresh follows a memory read but the response above is not held back for it.
          if (!io_q && !wr_q && REFRESH_EN) begin
            a_o      <= {9'b0, r_cnt};
            mreq_n_o <= 1'b0;
            rfsh_n_o <= 1'b0;
            state    <= RF1;
          end else begin
            state <= IDLE;
          end
        end
        RF1: if (clk_en_i) state <= RF2;
        RF2: if (clk_en_i) begin
          mreq_n_o <= 1'b1;
          rfsh_n_o <= 1'b1;
          r_cnt    <= r_cnt + 7'd1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cv_bus_master.sv
// Bench for cv_bus_master: vector table of bus commands, response scoreboard,
// and hand-written reset, back-to-back and refresh-counter sequences.
module tb_cv_bus_master;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        clk_en_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_io_i = 1'b0;
  logic        cmd_wr_i = 1'b0;
  logic [15:0] cmd_addr_i = 16'h0000;
  logic [7:0]  cmd_wdata_i = 8'h00;
  logic        rsp_valid_o;
  logic [7:0]  rsp_rdata_o;
  logic        rsp_err_o;
  logic [15:0] a_o;
  logic [7:0]  d_o;
  logic        d_oe_o;
  logic [7:0]  d_i = 8'h00;
  logic        mreq_n_o, iorq_n_o, rd_n_o, wr_n_o, rfsh_n_o;
  logic        wait_n_i = 1'b1;

  cv_bus_master #(.IO_WAIT(1), .WAIT_MAX(16), .REFRESH_EN(1'b1)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .clk_en_i(clk_en_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_io_i(cmd_io_i), .cmd_wr_i(cmd_wr_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .a_o(a_o), .d_o(d_o), .d_oe_o(d_oe_o), .d_i(d_i),
    .mreq_n_o(mreq_n_o), .iorq_n_o(iorq_n_o), .rd_n_o(rd_n_o),
    .wr_n_o(wr_n_o), .rfsh_n_o(rfsh_n_o), .wait_n_i(wait_n_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        io;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  din;
    int          wait_ticks;
    int          en_div;
    logic [7:0]  exp_rdata;
    logic        exp_err;
    int          exp_strb;
    int          exp_rfsh;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
  } rsp_t;

  rsp_t       sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         en_div  = 1;
  int         en_ph   = 0;
  logic [6:0] r_model = 7'd0;

  // Tick generator: clk_en_i high on one clk_i edge out of every en_div.
  always @(negedge clk_i) begin
    if (en_ph >= en_div - 1) begin
      en_ph    <= 0;
      clk_en_i <= 1'b1;
    end else begin
      en_ph    <= en_ph + 1;
      clk_en_i <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Response scoreboard: every rsp_valid pulse pops one expectation.
  always @(posedge clk_i) begin
    #1;
    if (rsp_valid_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid_o), 32'd0);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        chk("rsp_rdata", 32'(rsp_rdata_o), 32'(e.rdata));
        chk("rsp_err", 32'(rsp_err_o), 32'(e.err));
      end
    end
  end

  task automatic do_cmd(input vec_t v, input string nm);
    int         strb = 0, rf = 0, lat = 0, viol = 0, gap = 0, c_rsp = 0, wait_left;
    bit         rsp_seen = 0, done = 0, tick, ready_ok = 0, got_rf = 0;
    logic       prev_strb, prev_rf;
    logic [15:0] rf_addr = 16'hFFFF;
    en_div    = v.en_div;
    wait_left = v.wait_ticks;
    wait_n_i  = (wait_left == 0);
    d_i       = v.din;
    for (int k = 0; k < 100 && !ready_ok; k++) begin
      @(negedge clk_i);
      ready_ok = cmd_ready_o;
    end
    if (!ready_ok) chk({nm, "_ready_timeout"}, 32'(ready_ok), 32'd1);
    cmd_io_i    = v.io;
    cmd_wr_i    = v.wr;
    cmd_addr_i  = v.addr;
    cmd_wdata_i = v.wdata;
    cmd_valid_i = 1'b1;
    sb.push_back('{rdata: v.exp_rdata, err: v.exp_err});
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
    // First sample after acceptance is T1: address out, strobes idle.
    if (cmd_ready_o || d_oe_o !== v.wr || a_o !== v.addr ||
        {mreq_n_o, iorq_n_o, rd_n_o, wr_n_o, rfsh_n_o} !== 5'b11111) viol++;
    if (v.wr && d_o !== v.wdata) viol++;
    prev_strb = !rd_n_o || !wr_n_o;
    prev_rf   = !rfsh_n_o;
    for (int c = 0; c < 600 && !done; c++) begin
      @(posedge clk_i);
      tick = clk_en_i;
      #1;
      if (tick) begin
        if (!rsp_seen) lat++;
        if (prev_strb) strb++;
        if (prev_rf) rf++;
        if (prev_strb && wait_left > 0) wait_left--;
      end
      wait_n_i = (wait_left == 0);
      if ((!rd_n_o && !wr_n_o) || (!mreq_n_o && !iorq_n_o)) viol++;
      if (!rfsh_n_o) begin
        if (mreq_n_o || !rd_n_o || !wr_n_o || !iorq_n_o) viol++;
        if (!got_rf) begin
          got_rf  = 1;
          rf_addr = a_o;
        end
        if (a_o !== {9'b0, r_model}) viol++;
      end else if (!rd_n_o || !wr_n_o) begin
        if (a_o !== v.addr) viol++;
        if (v.io ? (!mreq_n_o || iorq_n_o) : (mreq_n_o || !iorq_n_o)) viol++;
        if (v.wr ? (!rd_n_o || !d_oe_o || d_o !== v.wdata) : (!wr_n_o || d_oe_o)) viol++;
      end
      if (rsp_valid_o) begin
        if (cmd_ready_o || !rd_n_o || !wr_n_o || !iorq_n_o || d_oe_o) viol++;
        rsp_seen = 1;
        c_rsp    = c;
      end
      if (rsp_seen && cmd_ready_o) begin
        done = 1;
        gap  = c - c_rsp;
      end
      prev_strb = !rd_n_o || !wr_n_o;
      prev_rf   = !rfsh_n_o;
    end
    wait_n_i = 1'b1;
    if (!done) chk({nm, "_timeout"}, 32'(done), 32'd1);
    chk({nm, "_strobe_ticks"}, 32'(strb), 32'(v.exp_strb));
    chk({nm, "_rfsh_ticks"}, 32'(rf), 32'(v.exp_rfsh));
    chk({nm, "_latency_ticks"}, 32'(lat), 32'(v.exp_lat));
    chk({nm, "_bus_violations"}, 32'(viol), 32'd0);
    if (v.exp_rfsh == 0) chk({nm, "_ready_gap"}, 32'(gap), 32'd1);
    else begin
      chk({nm, "_rfsh_addr"}, 32'(rf_addr), 32'({9'b0, r_model}));
      r_model = r_model + 7'd1;
    end
  endtask

  vec_t vecs[8];
  vec_t w;

  initial begin : main
    // io wr addr wdata din wait div | rdata err strb rfsh lat
    vecs[0] = '{1'b0, 1'b0, 16'h2000, 8'h00, 8'hA5, 0,    1, 8'hA5, 1'b0, 2,  2, 3};
    vecs[1] = '{1'b1, 1'b1, 16'h007F, 8'h0F, 8'h5A, 0,    1, 8'h00, 1'b0, 3,  0, 4};
    vecs[2] = '{1'b0, 1'b0, 16'h1234, 8'h00, 8'h3C, 3,    1, 8'h3C, 1'b0, 5,  2, 6};
    vecs[3] = '{1'b0, 1'b0, 16'h4000, 8'h00, 8'h77, 1000, 1, 8'hFF, 1'b1, 17, 0, 18};
    vecs[4] = '{1'b0, 1'b0, 16'h8001, 8'h00, 8'h11, 0,    4, 8'h11, 1'b0, 2,  2, 3};
    vecs[5] = '{1'b0, 1'b0, 16'h8002, 8'h00, 8'h22, 0,    4, 8'h22, 1'b0, 2,  2, 3};
    vecs[6] = '{1'b0, 1'b1, 16'h6000, 8'hC3, 8'h99, 0,    1, 8'h00, 1'b0, 2,  0, 3};
    vecs[7] = '{1'b1, 1'b0, 16'h00BE, 8'h00, 8'h9E, 0,    1, 8'h9E, 1'b0, 3,  0, 4};

    reset_n_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata_o), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err_o), 32'd0);
    chk("rst_strobes", 32'({mreq_n_o, iorq_n_o, rd_n_o, wr_n_o, rfsh_n_o}), 32'h1F);
    chk("rst_addr", 32'(a_o), 32'd0);
    chk("rst_dout", 32'(d_o), 32'd0);
    chk("rst_doe", 32'(d_oe_o), 32'd0);
    reset_n_i = 1'b1;

    for (int i = 0; i < 8; i++) do_cmd(vecs[i], $sformatf("vec%0d", i));

    // Reset during T2 of a memory write: strobes drop without a clock edge, no response.
    en_div = 1;
    repeat (3) @(negedge clk_i);
    cmd_io_i = 1'b0; cmd_wr_i = 1'b1; cmd_addr_i = 16'h3000; cmd_wdata_i = 8'h55;
    cmd_valid_i = 1'b1;
    @(posedge clk_i);
    #1 cmd_valid_i = 1'b0;
    @(posedge clk_i);
    #3;
    chk("t2_wr_low", 32'(wr_n_o), 32'd0);
    reset_n_i = 1'b0;
    #1;
    chk("async_wr_n", 32'(wr_n_o), 32'd1);
    chk("async_mreq_n", 32'(mreq_n_o), 32'd1);
    chk("async_doe", 32'(d_oe_o), 32'd0);
    chk("async_ready", 32'(cmd_ready_o), 32'd1);
    chk("async_rsp_valid", 32'(rsp_valid_o), 32'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    r_model = 7'd0;
    repeat (3) @(negedge clk_i);
    chk("post_rst_rsp_valid", 32'(rsp_valid_o), 32'd0);

    // Refresh counter: 130 reads walk R through 0x7F and back to 0x00.
    for (int i = 0; i < 130; i++) begin
      w = '{1'b0, 1'b0, 16'h2000 + 16'(i), 8'h00, 8'(i * 7), 0, 1, 8'(i * 7), 1'b0, 2, 2, 3};
      do_cmd(w, $sformatf("wrap%0d", i));
    end

    repeat (3) @(negedge clk_i);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
